// File: rtl/pcpi_coproc_dispatch.sv
// PCPI dispatcher: decodes custom R-type insns and runs one of NUM_UNITS units over STB/BUSY handshakes.
// Optional EXEC watchdog enabled by defining COPROC_TIMEOUT_EN.
module pcpi_coproc_dispatch #(
    parameter int         NUM_UNITS = 6,
    parameter int         RES_W     = 32,
    parameter int         SIGN_EXT  = 0,
    parameter logic [6:0] OPCODE    = 7'b0110011,
    parameter logic [6:0] FUNCT7    = 7'b0000001,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pcpi_valid,
    input  logic [31:0]                pcpi_insn,
    input  logic [31:0]                pcpi_rs1,
    input  logic [31:0]                pcpi_rs2,
    output logic                       pcpi_wr,
    output logic [31:0]                pcpi_rd,
    output logic                       pcpi_wait,
    output logic                       pcpi_ready,
    output logic [31:0]                unit_op_a,
    output logic [31:0]                unit_op_b,
    output logic [NUM_UNITS-1:0]       unit_in_stb,
    input  logic [NUM_UNITS-1:0]       unit_in_busy,
    input  logic [NUM_UNITS*RES_W-1:0] unit_result,
    input  logic [NUM_UNITS-1:0]       unit_out_stb,
    output logic [NUM_UNITS-1:0]       unit_out_busy
);
    localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]           state;
    logic [SEL_W-1:0]     sel;
    logic [31:0]          wb_data;
    logic                 match;
    logic                 out_hit;
    logic [RES_W-1:0]     sel_res;
    logic [31:0]          sel_ext;
    logic [NUM_UNITS-1:0] sel_oh;
    logic                 unused_insn;

    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    assign match = pcpi_valid && (pcpi_insn[6:0] == OPCODE) && (pcpi_insn[31:25] == FUNCT7)
                   && ({1'b0, pcpi_insn[14:12]} < 4'(NUM_UNITS));

    assign sel_res = unit_result[sel*RES_W +: RES_W];
    assign sel_oh  = NUM_UNITS'(1) << sel;
    // out_busy is a one-cycle pulse; gating on it stops a held out_stb being taken twice
    assign out_hit = unit_out_stb[sel] && !unit_out_busy[sel];

    generate
        if (RES_W < 32) begin : g_ext
            assign sel_ext = (SIGN_EXT != 0) ? {{(32-RES_W){sel_res[RES_W-1]}}, sel_res}
                                             : {{(32-RES_W){1'b0}}, sel_res};
        end else begin : g_pass
            assign sel_ext = sel_res;
        end
    endgenerate

`ifdef COPROC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0]     to_cnt;
    // units that timed out still owe one out_stb, which must be swallowed later
    logic [NUM_UNITS-1:0] stale;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            sel           <= '0;
            wb_data       <= '0;
            pcpi_wr       <= 1'b0;
            pcpi_rd       <= '0;
            pcpi_wait     <= 1'b0;
            pcpi_ready    <= 1'b0;
            unit_op_a     <= '0;
            unit_op_b     <= '0;
            unit_in_stb   <= '0;
            unit_out_busy <= '0;
`ifdef COPROC_TIMEOUT_EN
            to_cnt        <= '0;
            stale         <= '0;
`endif
        end else begin
            pcpi_ready    <= 1'b0;
            pcpi_wr       <= 1'b0;
            pcpi_rd       <= '0;
            unit_out_busy <= '0;
            case (state)
                S_IDLE: begin
                    // the core still holds valid during the ready cycle; don't re-claim it
                    if (match && !pcpi_ready) begin
                        unit_op_a   <= pcpi_rs1;
                        unit_op_b   <= pcpi_rs2;
                        sel         <= SEL_W'(pcpi_insn[14:12]);
                        unit_in_stb <= NUM_UNITS'(1) << pcpi_insn[14:12];
                        pcpi_wait   <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!pcpi_valid) begin
                        unit_in_stb <= '0;
                        pcpi_wait   <= 1'b0;
                        state       <= S_IDLE;
                    end else if (unit_in_busy[sel]) begin
                        unit_in_stb <= '0;
                        state       <= S_EXEC;
`ifdef COPROC_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    if (!pcpi_valid) begin
                        pcpi_wait <= 1'b0;
                        state     <= S_DRAIN;
                    end
`ifdef COPROC_TIMEOUT_EN
                    else if (stale[sel] && out_hit) begin
                        unit_out_busy <= sel_oh;
                        stale[sel]    <= 1'b0;
                    end
`endif
                    else if (out_hit) begin
                        wb_data       <= sel_ext;
                        unit_out_busy <= sel_oh;
                        state         <= S_WB;
                    end
`ifdef COPROC_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT-1)) begin
                        wb_data    <= 32'hFFFF_FFFF;
                        stale[sel] <= 1'b1;
                        state      <= S_WB;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_WB: begin
                    pcpi_ready <= 1'b1;
                    pcpi_wr    <= 1'b1;
                    pcpi_rd    <= wb_data;
                    pcpi_wait  <= 1'b0;
                    state      <= S_IDLE;
                end
                S_DRAIN: begin
                    if (out_hit) begin
                        unit_out_busy <= sel_oh;
                        state         <= S_IDLE;
`ifdef COPROC_TIMEOUT_EN
                        stale[sel]    <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcpi_coproc_dispatch.sv
// Directed bench for pcpi_coproc_dispatch: a sign-extending and a zero-extending instance share stimulus.
module tb_pcpi_coproc_dispatch;
    localparam int NU = 6;
    localparam int RW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic             pcpi_valid;
    logic [31:0]      pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic [NU-1:0]    unit_in_busy, unit_out_stb;
    logic [NU*RW-1:0] unit_result;

    logic          s_wr, s_wait, s_ready, z_wr, z_wait, z_ready;
    logic [31:0]   s_rd, s_op_a, s_op_b, z_rd, z_op_a, z_op_b;
    logic [NU-1:0] s_in_stb, s_out_busy, z_in_stb, z_out_busy;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] exp_s[$];
    logic [31:0] exp_z[$];

    pcpi_coproc_dispatch #(.NUM_UNITS(NU), .RES_W(RW), .SIGN_EXT(1), .TIMEOUT(8)) u_s (
        .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(s_wr), .pcpi_rd(s_rd),
        .pcpi_wait(s_wait), .pcpi_ready(s_ready), .unit_op_a(s_op_a), .unit_op_b(s_op_b),
        .unit_in_stb(s_in_stb), .unit_in_busy(unit_in_busy), .unit_result(unit_result),
        .unit_out_stb(unit_out_stb), .unit_out_busy(s_out_busy));

    pcpi_coproc_dispatch #(.NUM_UNITS(NU), .RES_W(RW), .SIGN_EXT(0), .TIMEOUT(8)) u_z (
        .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(z_wr), .pcpi_rd(z_rd),
        .pcpi_wait(z_wait), .pcpi_ready(z_ready), .unit_op_a(z_op_a), .unit_op_b(z_op_b),
        .unit_in_stb(z_in_stb), .unit_in_busy(unit_in_busy), .unit_result(unit_result),
        .unit_out_stb(unit_out_stb), .unit_out_busy(z_out_busy));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int f);
        return {7'b0000001, 5'd2, 5'd1, 3'(f), 5'd3, 7'b0110011};
    endfunction

    function automatic logic [NU-1:0] oh(input int f);
        return NU'(1) << f;
    endfunction

    // Present an instruction and record what both instances must write back.
    task automatic start(input int f, input logic [31:0] a, input logic [31:0] b, input logic [15:0] res);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(f);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        unit_result[f*RW +: RW] = res;
        exp_s.push_back({{16{res[15]}}, res});
        exp_z.push_back({16'h0000, res});
    endtask

    // Act as unit f from the claim edge through the ready cycle (out_lat >= 2 EXEC cycles).
    task automatic serve(input int f, input int out_lat);
        tick;
        chk("claim_wait", 32'(s_wait), 32'd1);
        chk("in_stb", 32'(s_in_stb), 32'(oh(f)));
        chk("op_a", s_op_a, pcpi_rs1);
        chk("op_b", s_op_b, pcpi_rs2);
        tick;
        chk("in_stb_hold", 32'(s_in_stb), 32'(oh(f)));
        unit_in_busy = oh(f);
        tick;
        unit_in_busy = '0;
        chk("in_stb_drop", 32'(s_in_stb), 32'd0);
        unit_out_stb = oh((f + 1) % NU);
        tick;
        unit_out_stb = '0;
        chk("foreign_out_stb", 32'(s_out_busy), 32'd0);
        chk("exec_wait", 32'(s_wait), 32'd1);
        repeat (out_lat - 2) tick;
        unit_out_stb = oh(f);
        tick;
        unit_out_stb = '0;
        chk("out_busy", 32'(s_out_busy), 32'(oh(f)));
        chk("no_early_ready", 32'(s_ready), 32'd0);
        tick;
        chk("ready", 32'(s_ready), 32'd1);
        chk("wr", 32'(s_wr), 32'd1);
        chk("wait_clr", 32'(s_wait), 32'd0);
        chk("out_busy_1cyc", 32'(s_out_busy), 32'd0);
        chk("rd_sext", s_rd, exp_s.pop_front());
        chk("rd_zext", z_rd, exp_z.pop_front());
    endtask

    initial begin
        pcpi_valid = 1'b1; pcpi_insn = mk(0); pcpi_rs1 = 32'h1; pcpi_rs2 = 32'h2;
        unit_in_busy = '0; unit_out_stb = '0; unit_result = '0;

        // reset holds everything idle even with a matching insn presented
        repeat (3) tick;
        chk("rst_wait", 32'(s_wait), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_wr", 32'(s_wr), 32'd0);
        chk("rst_rd", s_rd, 32'd0);
        chk("rst_op_a", s_op_a, 32'd0);
        chk("rst_op_b", s_op_b, 32'd0);
        chk("rst_in_stb", 32'(s_in_stb), 32'd0);
        chk("rst_out_busy", 32'(s_out_busy), 32'd0);
        pcpi_valid = 1'b0;
        rst = 1'b1;
        tick;

        // basic op on unit 0
        start(0, 32'd3, 32'd4, 16'h0007);
        serve(0, 5);
        pcpi_valid = 1'b0;
        tick;
        chk("ready_1cyc", 32'(s_ready), 32'd0);
        chk("wr_1cyc", 32'(s_wr), 32'd0);
        chk("rd_return0", s_rd, 32'd0);

        // sign vs zero extension
        start(3, 32'h0000_dead, 32'h0000_beef, 16'h8001);
        serve(3, 3);
        pcpi_valid = 1'b0;
        tick;

        // funct3 beyond NUM_UNITS and a wrong funct7 are never claimed
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(6);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("f3_6_wait", 32'(s_wait), 32'd0);
            chk("f3_6_ready", 32'(s_ready), 32'd0);
            chk("f3_6_stb", 32'(s_in_stb), 32'd0);
        end
        pcpi_insn = mk(1) & 32'h01FF_FFFF;
        repeat (3) tick;
        chk("bad_f7_wait", 32'(s_wait), 32'd0);
        chk("bad_f7_stb", 32'(s_in_stb), 32'd0);
        pcpi_valid = 1'b0;
        tick;

        // abort during ISSUE
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(2);
        tick;
        chk("iss_stb", 32'(s_in_stb), 32'(oh(2)));
        pcpi_valid = 1'b0;
        tick;
        chk("iss_abort_stb", 32'(s_in_stb), 32'd0);
        chk("iss_abort_wait", 32'(s_wait), 32'd0);
        tick;
        chk("iss_abort_ready", 32'(s_ready), 32'd0);

        // abort during EXEC, drain blocks a new claim, then the queued op runs
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(4);
        tick;
        unit_in_busy = oh(4);
        tick;
        unit_in_busy = '0;
        pcpi_valid   = 1'b0;
        tick;
        chk("exec_abort_wait", 32'(s_wait), 32'd0);
        start(1, 32'd5, 32'd6, 16'h1234);
        tick;
        chk("drain_block1", 32'(s_wait), 32'd0);
        tick;
        chk("drain_block2", 32'(s_wait), 32'd0);
        unit_result[4*RW +: RW] = 16'h5555;
        unit_out_stb = oh(4);
        tick;
        unit_out_stb = '0;
        chk("drain_out_busy", 32'(s_out_busy), 32'(oh(4)));
        chk("drain_no_ready", 32'(s_ready), 32'd0);
        chk("drain_no_wr", 32'(s_wr), 32'd0);
        chk("drain_no_wait", 32'(s_wait), 32'd0);
        serve(1, 2);

        // back-to-back: next insn not claimed during the ready cycle
        start(2, 32'd7, 32'd8, 16'hfffe);
        tick;
        chk("b2b_blocked", 32'(s_wait), 32'd0);
        chk("b2b_stb", 32'(s_in_stb), 32'd0);
        chk("b2b_rd0", s_rd, 32'd0);
        serve(2, 2);
        pcpi_valid = 1'b0;
        tick;

        // reset mid-operation
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(5);
        tick;
        unit_in_busy = oh(5);
        tick;
        unit_in_busy = '0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        pcpi_valid = 1'b0;
        chk("midrst_wait", 32'(s_wait), 32'd0);
        chk("midrst_stb", 32'(s_in_stb), 32'd0);
        unit_out_stb = oh(5);
        tick;
        unit_out_stb = '0;
        chk("midrst_out_busy", 32'(s_out_busy), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd0);
        start(5, 32'd1, 32'd2, 16'h00ff);
        serve(5, 2);
        pcpi_valid = 1'b0;
        tick;

        // silent unit: watchdog completes with all-ones, otherwise EXEC holds
        pcpi_valid = 1'b1;
        pcpi_insn  = mk(0);
        tick;
        unit_in_busy = oh(0);
        tick;
        unit_in_busy = '0;
`ifdef COPROC_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!s_ready && n < 40) begin
                tick;
                n++;
            end
            chk("to_ready", 32'(s_ready), 32'd1);
            chk("to_rd", s_rd, 32'hFFFF_FFFF);
            chk("to_rd_z", z_rd, 32'hFFFF_FFFF);
            chk("to_no_out_busy", 32'(s_out_busy), 32'd0);
        end
        pcpi_valid = 1'b0;
        tick;
`else
        repeat (30) tick;
        chk("hold_wait", 32'(s_wait), 32'd1);
        chk("hold_ready", 32'(s_ready), 32'd0);
        pcpi_valid = 1'b0;
        tick;
        unit_out_stb = oh(0);
        tick;
        unit_out_stb = '0;
        chk("hold_drain_busy", 32'(s_out_busy), 32'(oh(0)));
        tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
